i2s_tx_ctrl: RTL and testbench

I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

---
 rtl/i2s_pkg.sv | 30 +++
 rtl/i2s_sample_fifo.sv | 72 +++++++
 rtl/i2s_tx_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S transmit controller slice.
package i2s_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_DW    = 32;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_RUN   = 2'b10,
    ST_DRAIN = 2'b11
  } state_e;

  // Behaviour of the transmit data when a request finds the FIFO empty.
  typedef enum logic {
    URUN_ZERO   = 1'b0,
    URUN_REPEAT = 1'b1
  } urun_mode_e;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return v + 16'h0001;
    end
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo-pair sample FIFO: power-of-two depth, first-word-fall-through read,
// synchronous flush and an explicit occupancy output.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = 2 * DEF_DW
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [W-1:0]           i_wr_data,
  input  logic                   i_rd_en,
  output logic [W-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_wr;
  logic          w_rd;

  // Guard the enables so the level can neither overflow nor underflow.
  assign w_wr = i_wr_en & (r_level != LVL_FULL) & ~i_flush;
  assign w_rd = i_rd_en & (r_level != LVL_ZERO) & ~i_flush;

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Sample storage; contents are only observed behind a non-zero level, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
    end else if (i_flush) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: buffers stereo pairs and feeds an external I2S
// master one pair per data request, with underrun handling and interrupts.
module i2s_tx_ctrl
  import i2s_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   cfg_en,
  input  logic                   cfg_mute,
  input  logic                   cfg_urun_mode,
  input  logic                   cfg_flush,
  input  logic [$clog2(DEPTH):0] cfg_thresh,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DW-1:0]          wr_left,
  input  logic [DW-1:0]          wr_right,
  input  logic                   tx_data_rqst,
  output logic                   tx_enable,
  output logic [DW-1:0]          tx_data_left,
  output logic [DW-1:0]          tx_data_right,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            underrun_cnt,
  output logic                   busy,
  output logic                   irq_level,
  output logic                   irq_urun,
  input  logic                   irq_clr
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};

  state_e          r_state;
  state_e          w_state_nxt;
  urun_mode_e      w_urun_mode;
  logic [LW-1:0]   w_level;
  logic [2*DW-1:0] w_fifo_rd;
  logic [2*DW-1:0] w_data_nxt;
  logic            w_pop;
  logic            w_urun;
  logic            w_flush;
  logic            w_wr_en;
  logic            w_tx_enable_nxt;
  logic [15:0]     w_cnt_base;
  logic [15:0]     w_cnt_nxt;
  logic [DW-1:0]   r_tx_left;
  logic [DW-1:0]   r_tx_right;
  logic            r_tx_enable;
  logic            r_irq_urun;
  logic [15:0]     r_urun_cnt;

  assign w_urun_mode = urun_mode_e'(cfg_urun_mode);

  // Flush is honoured only while idle; a write in the same cycle is refused.
  assign w_flush  = cfg_flush & (r_state == ST_IDLE);
  assign wr_ready = nrst & (w_level < LVL_FULL) & ~w_flush;
  assign w_wr_en  = wr_valid & wr_ready;

  i2s_sample_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * DW)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .i_flush   (w_flush),
    .i_wr_en   (w_wr_en),
    .i_wr_data ({wr_left, wr_right}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rd),
    .o_level   (w_level)
  );

  // Next-state and pop/underrun decode; requests are only serviced in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_urun      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_en) begin
          w_state_nxt = ST_PRIME;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (!cfg_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_level != LVL_ZERO) begin
          // Preload the first pair so it is valid before the first request.
          w_state_nxt = ST_RUN;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (tx_data_rqst) begin
          if (w_level != LVL_ZERO) begin
            w_pop = 1'b1;
          end else begin
            w_urun = 1'b1;
          end
        end else begin
          w_pop  = 1'b0;
          w_urun = 1'b0;
        end
        if (!cfg_en) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (tx_data_rqst) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transmitter stays enabled for the whole RUN/DRAIN window.
  assign w_tx_enable_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);

  // Select the next transmit pair: popped data, zero, or hold; mute forces zero.
  always_comb begin
    w_data_nxt = {r_tx_left, r_tx_right};
    if (w_pop) begin
      if (cfg_mute) begin
        w_data_nxt = {(2*DW){1'b0}};
      end else begin
        w_data_nxt = w_fifo_rd;
      end
    end else if (w_urun) begin
      if (cfg_mute || (w_urun_mode == URUN_ZERO)) begin
        w_data_nxt = {(2*DW){1'b0}};
      end else begin
        w_data_nxt = {r_tx_left, r_tx_right};
      end
    end else begin
      w_data_nxt = {r_tx_left, r_tx_right};
    end
  end

  // Underrun counter: clear first, then a concurrent underrun still counts.
  always_comb begin
    w_cnt_base = irq_clr ? 16'h0000 : r_urun_cnt;
    if (w_urun) begin
      w_cnt_nxt = sat_inc16(w_cnt_base);
    end else begin
      w_cnt_nxt = w_cnt_base;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transmit enable and data registers; reset drops enable asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_enable <= 1'b0;
      r_tx_left   <= {DW{1'b0}};
      r_tx_right  <= {DW{1'b0}};
    end else begin
      r_tx_enable <= w_tx_enable_nxt;
      r_tx_left   <= w_data_nxt[2*DW-1:DW];
      r_tx_right  <= w_data_nxt[DW-1:0];
    end
  end

  // Sticky underrun interrupt (set beats clear) and its event counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_irq_urun <= 1'b0;
      r_urun_cnt <= 16'h0000;
    end else begin
      if (w_urun) begin
        r_irq_urun <= 1'b1;
      end else if (irq_clr) begin
        r_irq_urun <= 1'b0;
      end
      r_urun_cnt <= w_cnt_nxt;
    end
  end

  assign tx_enable     = r_tx_enable;
  assign tx_data_left  = r_tx_left;
  assign tx_data_right = r_tx_right;
  assign fifo_level    = w_level;
  assign underrun_cnt  = r_urun_cnt;
  assign irq_urun      = r_irq_urun;
  assign busy          = (r_state != ST_IDLE);
  assign irq_level     = busy & (w_level <= cfg_thresh);

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl: directed scenarios plus a randomized
// stream checked against a queue-based model of the pair buffer.
module tb_i2s_tx_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic          cfg_en, cfg_mute, cfg_urun_mode, cfg_flush;
  logic [LW-1:0] cfg_thresh;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_left, wr_right;
  logic          tx_data_rqst;
  logic          tx_enable;
  logic [DW-1:0] tx_data_left, tx_data_right;
  logic [LW-1:0] fifo_level;
  logic [15:0]   underrun_cnt;
  logic          busy, irq_level, irq_urun, irq_clr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*DW-1:0] q[$];

  i2s_tx_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .nrst(nrst), .cfg_en(cfg_en), .cfg_mute(cfg_mute),
    .cfg_urun_mode(cfg_urun_mode), .cfg_flush(cfg_flush), .cfg_thresh(cfg_thresh),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_left(wr_left), .wr_right(wr_right),
    .tx_data_rqst(tx_data_rqst), .tx_enable(tx_enable), .tx_data_left(tx_data_left),
    .tx_data_right(tx_data_right), .fifo_level(fifo_level), .underrun_cnt(underrun_cnt),
    .busy(busy), .irq_level(irq_level), .irq_urun(irq_urun), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    wr_left = l; wr_right = r; wr_valid = 1'b1;
    cyc();
    wr_valid = 1'b0;
    q.push_back({l, r});
  endtask

  task automatic rqst();
    tx_data_rqst = 1'b1;
    cyc();
    tx_data_rqst = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; cfg_en = 1'b0; cfg_mute = 1'b0; cfg_urun_mode = 1'b0; cfg_flush = 1'b0;
    cfg_thresh = '0; wr_valid = 1'b0; wr_left = '0; wr_right = '0; tx_data_rqst = 1'b0; irq_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_enable, busy, irq_urun, irq_level, wr_ready} !== 5'b00000)
      $display("FAIL reset_flags: got %b want 00000", {tx_enable, busy, irq_urun, irq_level, wr_ready});
    else n_pass++;
    n_checks++;
    if (fifo_level !== 4'd0 || underrun_cnt !== 16'h0000)
      $display("FAIL reset_counts: level %0d cnt %0d want 0 0", fifo_level, underrun_cnt);
    else n_pass++;
    n_checks++;
    if ({tx_data_left, tx_data_right} !== 64'h0)
      $display("FAIL reset_data: got %h want 0", {tx_data_left, tx_data_right});
    else n_pass++;
    @(negedge clk);
    nrst = 1'b1;
    cyc();
    n_checks++;
    if ({wr_ready, busy} !== 2'b10 || fifo_level !== 4'd0)
      $display("FAIL post_reset: ready/busy %b level %0d want 10 0", {wr_ready, busy}, fifo_level);
    else n_pass++;
  endtask

  task automatic test_basic_stream();
    logic [2*DW-1:0] e;
    q.delete();
    cfg_urun_mode = 1'b0;
    for (int i = 1; i <= 3; i++) push(32'h1111_1100 + i, 32'h2222_2200 + i);
    n_checks++;
    if (fifo_level !== 4'd3) $display("FAIL bs_fill: level %0d want 3", fifo_level); else n_pass++;
    cfg_en = 1'b1;
    cyc();
    n_checks++;
    if ({busy, tx_enable} !== 2'b10) $display("FAIL bs_prime: busy/en %b want 10", {busy, tx_enable}); else n_pass++;
    cyc();
    e = q.pop_front();
    n_checks++;
    if (tx_enable !== 1'b1 || {tx_data_left, tx_data_right} !== e || fifo_level !== 4'd2)
      $display("FAIL bs_first: en %b data %h level %0d want 1 %h 2", tx_enable, {tx_data_left, tx_data_right}, fifo_level, e);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 3)) begin
        cyc();
        n_checks++;
        if ({tx_data_left, tx_data_right} !== e)
          $display("FAIL bs_hold: got %h want %h", {tx_data_left, tx_data_right}, e);
        else n_pass++;
      end
      rqst();
      e = q.pop_front();
      n_checks++;
      if ({tx_data_left, tx_data_right} !== e || fifo_level !== LW'(q.size()))
        $display("FAIL bs_pop%0d: data %h level %0d want %h %0d", k, {tx_data_left, tx_data_right}, fifo_level, e, q.size());
      else n_pass++;
    end
    rqst();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== 64'h0 || underrun_cnt !== 16'd1 || irq_urun !== 1'b1)
      $display("FAIL bs_urun: data %h cnt %0d irq %b want 0 1 1", {tx_data_left, tx_data_right}, underrun_cnt, irq_urun);
    else n_pass++;
    cfg_en = 1'b0;
    cyc();
    n_checks++;
    if ({busy, tx_enable} !== 2'b11) $display("FAIL bs_drain: busy/en %b want 11", {busy, tx_enable}); else n_pass++;
    rqst();
    n_checks++;
    if ({busy, tx_enable} !== 2'b00) $display("FAIL bs_idle: busy/en %b want 00", {busy, tx_enable}); else n_pass++;
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    n_checks++;
    if (irq_urun !== 1'b0 || underrun_cnt !== 16'd0)
      $display("FAIL bs_clr: irq %b cnt %0d want 0 0", irq_urun, underrun_cnt);
    else n_pass++;
  endtask

  task automatic test_underrun_modes();
    logic [2*DW-1:0] e;
    q.delete();
    push(32'hA5A5_0000, 32'h5A5A_0000);
    cfg_en = 1'b1; cyc(); cyc();
    e = q.pop_front();
    cfg_urun_mode = 1'b1;
    rqst();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== e || underrun_cnt !== 16'd1 || irq_urun !== 1'b1)
      $display("FAIL um_repeat: data %h cnt %0d irq %b want %h 1 1", {tx_data_left, tx_data_right}, underrun_cnt, irq_urun, e);
    else n_pass++;
    rqst();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== e || underrun_cnt !== 16'd2)
      $display("FAIL um_repeat2: data %h cnt %0d want %h 2", {tx_data_left, tx_data_right}, underrun_cnt, e);
    else n_pass++;
    cfg_urun_mode = 1'b0;
    rqst();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== 64'h0 || underrun_cnt !== 16'd3)
      $display("FAIL um_zero: data %h cnt %0d want 0 3", {tx_data_left, tx_data_right}, underrun_cnt);
    else n_pass++;
    irq_clr = 1'b1; tx_data_rqst = 1'b1; cyc(); irq_clr = 1'b0; tx_data_rqst = 1'b0;
    n_checks++;
    if (irq_urun !== 1'b1) $display("FAIL um_set_wins: irq %b want 1", irq_urun); else n_pass++;
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    n_checks++;
    if (irq_urun !== 1'b0 || underrun_cnt !== 16'd0)
      $display("FAIL um_clr: irq %b cnt %0d want 0 0", irq_urun, underrun_cnt);
    else n_pass++;
    push($urandom, $urandom);
    push($urandom, $urandom);
    cfg_mute = 1'b1;
    rqst();
    void'(q.pop_front());
    n_checks++;
    if ({tx_data_left, tx_data_right} !== 64'h0 || fifo_level !== 4'd1 || underrun_cnt !== 16'd0)
      $display("FAIL um_mute_pop: data %h level %0d cnt %0d want 0 1 0", {tx_data_left, tx_data_right}, fifo_level, underrun_cnt);
    else n_pass++;
    cfg_mute = 1'b0;
    rqst();
    e = q.pop_front();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== e || fifo_level !== 4'd0)
      $display("FAIL um_unmute: data %h level %0d want %h 0", {tx_data_left, tx_data_right}, fifo_level, e);
    else n_pass++;
    cfg_mute = 1'b1; cfg_urun_mode = 1'b1;
    rqst();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== 64'h0 || underrun_cnt !== 16'd1)
      $display("FAIL um_mute_urun: data %h cnt %0d want 0 1", {tx_data_left, tx_data_right}, underrun_cnt);
    else n_pass++;
    cfg_mute = 1'b0; cfg_urun_mode = 1'b0;
    cfg_en = 1'b0; cyc(); rqst();
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
  endtask

  task automatic test_full();
    logic [2*DW-1:0] e;
    q.delete();
    for (int i = 0; i < DEPTH; i++) push($urandom, $urandom);
    n_checks++;
    if (fifo_level !== 4'd8 || wr_ready !== 1'b0)
      $display("FAIL fu_full: level %0d ready %b want 8 0", fifo_level, wr_ready);
    else n_pass++;
    wr_left = $urandom; wr_right = $urandom; wr_valid = 1'b1; cyc(); wr_valid = 1'b0;
    n_checks++;
    if (fifo_level !== 4'd8) $display("FAIL fu_refuse_idle: level %0d want 8", fifo_level); else n_pass++;
    cfg_en = 1'b1; cyc(); cyc();
    e = q.pop_front();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== e || fifo_level !== 4'd7 || wr_ready !== 1'b1)
      $display("FAIL fu_run: data %h level %0d ready %b want %h 7 1", {tx_data_left, tx_data_right}, fifo_level, wr_ready, e);
    else n_pass++;
    push($urandom, $urandom);
    wr_left = $urandom; wr_right = $urandom; wr_valid = 1'b1; tx_data_rqst = 1'b1;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL fu_ready_at_pop: ready %b want 0", wr_ready); else n_pass++;
    cyc();
    wr_valid = 1'b0; tx_data_rqst = 1'b0;
    e = q.pop_front();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== e || fifo_level !== 4'd7)
      $display("FAIL fu_wr_pop: data %h level %0d want %h 7", {tx_data_left, tx_data_right}, fifo_level, e);
    else n_pass++;
    cfg_thresh = 4'd2;
    while (q.size() > 0) begin
      rqst();
      e = q.pop_front();
      n_checks++;
      if ({tx_data_left, tx_data_right} !== e || fifo_level !== LW'(q.size()) || irq_level !== (q.size() <= 2))
        $display("FAIL fu_drain: data %h level %0d irql %b want %h %0d %b", {tx_data_left, tx_data_right}, fifo_level, irq_level, e, q.size(), (q.size() <= 2));
      else n_pass++;
    end
    rqst();
    n_checks++;
    if ({tx_data_left, tx_data_right} !== 64'h0 || fifo_level !== 4'd0 || irq_level !== 1'b1)
      $display("FAIL fu_empty: data %h level %0d irql %b want 0 0 1", {tx_data_left, tx_data_right}, fifo_level, irq_level);
    else n_pass++;
    cfg_en = 1'b0; cyc(); rqst();
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    cfg_thresh = 4'd0;
  endtask

  task automatic test_drain_flush();
    logic [2*DW-1:0] e;
    q.delete();
    for (int i = 0; i < 5; i++) push($urandom, $urandom);
    cfg_en = 1'b1; cyc(); cyc();
    e = q.pop_front();
    cfg_en = 1'b0; cyc();
    n_checks++;
    if ({busy, tx_enable} !== 2'b11 || fifo_level !== 4'd4)
      $display("FAIL df_drain: busy/en %b level %0d want 11 4", {busy, tx_enable}, fifo_level);
    else n_pass++;
    rqst();
    n_checks++;
    if ({busy, tx_enable} !== 2'b00 || fifo_level !== 4'd4 || {tx_data_left, tx_data_right} !== e)
      $display("FAIL df_exit: busy/en %b level %0d data %h want 00 4 %h", {busy, tx_enable}, fifo_level, {tx_data_left, tx_data_right}, e);
    else n_pass++;
    rqst();
    n_checks++;
    if (fifo_level !== 4'd4 || underrun_cnt !== 16'd0 || {tx_data_left, tx_data_right} !== e)
      $display("FAIL df_idle_rqst: level %0d cnt %0d data %h want 4 0 %h", fifo_level, underrun_cnt, {tx_data_left, tx_data_right}, e);
    else n_pass++;
    cfg_flush = 1'b1; wr_valid = 1'b1;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL df_flush_ready: ready %b want 0", wr_ready); else n_pass++;
    cyc();
    cfg_flush = 1'b0; wr_valid = 1'b0;
    q.delete();
    n_checks++;
    if (fifo_level !== 4'd0) $display("FAIL df_flush: level %0d want 0", fifo_level); else n_pass++;
    push($urandom, $urandom);
    push($urandom, $urandom);
    cfg_en = 1'b1; cyc();
    cfg_flush = 1'b1; cyc(); cfg_flush = 1'b0;
    e = q.pop_front();
    n_checks++;
    if (fifo_level !== 4'd1 || {tx_data_left, tx_data_right} !== e || tx_enable !== 1'b1)
      $display("FAIL df_flush_ign: level %0d data %h en %b want 1 %h 1", fifo_level, {tx_data_left, tx_data_right}, tx_enable, e);
    else n_pass++;
    cfg_en = 1'b0; cyc(); rqst();
    cfg_flush = 1'b1; cyc(); cfg_flush = 1'b0;
    q.delete();
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] e;
    int exp_cnt;
    logic exp_irq;
    q.delete();
    exp_cnt = 0; exp_irq = 1'b0;
    for (int i = 0; i < 4; i++) push($urandom, $urandom);
    cfg_en = 1'b1; cyc(); cyc();
    e = q.pop_front();
    for (int c = 0; c < 300; c++) begin
      logic do_wr, do_rq, do_clr;
      logic [DW-1:0] l, r;
      int L;
      if (c < 100) begin
        do_wr = ($urandom_range(0, 99) < 60); do_rq = ($urandom_range(0, 99) < 30);
      end else if (c < 200) begin
        do_wr = ($urandom_range(0, 99) < 70); do_rq = 1'b1;
      end else begin
        do_wr = ($urandom_range(0, 99) < 40); do_rq = ($urandom_range(0, 99) < 60);
      end
      do_clr = !do_rq && ($urandom_range(0, 99) < 5);
      l = $urandom; r = $urandom;
      cfg_mute = ($urandom_range(0, 99) < 20);
      cfg_urun_mode = $urandom_range(0, 1);
      wr_left = l; wr_right = r; wr_valid = do_wr; tx_data_rqst = do_rq; irq_clr = do_clr;
      #1;
      L = q.size();
      n_checks++;
      if (wr_ready !== (L < DEPTH)) $display("FAIL rs_ready c=%0d: got %b want %b", c, wr_ready, (L < DEPTH));
      else n_pass++;
      if (do_clr) begin
        exp_irq = 1'b0; exp_cnt = 0;
      end
      if (do_rq) begin
        if (L > 0) begin
          e = q.pop_front();
          if (cfg_mute) e = '0;
        end else begin
          if (cfg_mute || !cfg_urun_mode) e = '0;
          exp_cnt = (exp_cnt == 65535) ? 65535 : exp_cnt + 1;
          exp_irq = 1'b1;
        end
      end
      if (do_wr && L < DEPTH) q.push_back({l, r});
      cyc();
      wr_valid = 1'b0; tx_data_rqst = 1'b0; irq_clr = 1'b0;
      n_checks++;
      if ({tx_data_left, tx_data_right} !== e || fifo_level !== LW'(q.size()) || underrun_cnt !== 16'(exp_cnt) || irq_urun !== exp_irq)
        $display("FAIL rs_state c=%0d: data %h lvl %0d cnt %0d irq %b want %h %0d %0d %b", c, {tx_data_left, tx_data_right}, fifo_level, underrun_cnt, irq_urun, e, q.size(), exp_cnt, exp_irq);
      else n_pass++;
    end
    cfg_mute = 1'b0; cfg_urun_mode = 1'b0;
    cfg_en = 1'b0; cyc(); rqst();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rs_stop: busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    q.delete();
    cfg_flush = 1'b1; cyc(); cfg_flush = 1'b0;
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    for (int i = 0; i < 3; i++) push($urandom, $urandom);
    cfg_en = 1'b1; cyc(); cyc();
    rqst(); rqst(); rqst();
    n_checks++;
    if (underrun_cnt !== 16'd1 || tx_enable !== 1'b1)
      $display("FAIL rr_pre: cnt %0d en %b want 1 1", underrun_cnt, tx_enable);
    else n_pass++;
    push($urandom, $urandom);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({tx_enable, busy, irq_urun, wr_ready} !== 4'b0000 || fifo_level !== 4'd0 || underrun_cnt !== 16'd0 || {tx_data_left, tx_data_right} !== 64'h0)
      $display("FAIL rr_async: en/busy/irq/rdy %b level %0d cnt %0d data %h want 0000 0 0 0", {tx_enable, busy, irq_urun, wr_ready}, fifo_level, underrun_cnt, {tx_data_left, tx_data_right});
    else n_pass++;
    cfg_en = 1'b0;
    q.delete();
    @(negedge clk);
    nrst = 1'b1;
    cyc();
    n_checks++;
    if ({busy, tx_enable, wr_ready} !== 3'b001 || fifo_level !== 4'd0)
      $display("FAIL rr_release: busy/en/rdy %b level %0d want 001 0", {busy, tx_enable, wr_ready}, fifo_level);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_underrun_modes();
    test_full();
    test_drain_flush();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
